// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS final conditional-subtraction stage.
package fios_pkg;

  localparam int WORD_W = 17;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SELECT  = 2'd2,
    ST_OUTPUT  = 2'd3
  } fios_final_sub_state_t;

endpackage

// File: rtl/fios_word_sub.sv
// One word of the multi-word subtraction T - p, with borrow chained word to word.
module fios_word_sub
  import fios_pkg::*;
(
  input  logic [WORD_W-1:0] t_i,
  input  logic [WORD_W-1:0] p_i,
  input  logic              b_i,
  output logic [WORD_W-1:0] d_o,
  output logic              b_o
);

  logic [WORD_W:0] diff_ext;

  // The extra top bit goes to one exactly when T < p + b_in.
  always_comb begin
    diff_ext = {1'b0, t_i} - {1'b0, p_i} - {{WORD_W{1'b0}}, b_i};
    d_o      = diff_ext[WORD_W-1:0];
    b_o      = diff_ext[WORD_W];
  end

endmodule

// File: rtl/fios_final_sub.sv
// Final Montgomery correction: buffers T and T-p word by word, then streams out
// whichever of the two is the reduced result once the final borrow is known.
module fios_final_sub
  import fios_pkg::*;
#(
  parameter int S = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              res_valid_i,
  input  logic [WORD_W-1:0] res_i,
  input  logic [WORD_W-1:0] p_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int CNT_W = $clog2(S);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(S - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  fios_final_sub_state_t state_q, state_d;
  logic [CNT_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]      j_q, j_d;
  logic                  borrow_q, borrow_d;
  logic                  sel_q, sel_d;
  logic                  overrun_q, overrun_d;

  word_t t_mem_q [S];
  word_t d_mem_q [S];

  logic             word_we;
  logic [CNT_W-1:0] wr_idx;
  logic             b_in;
  word_t            diff;
  logic             b_out;

  fios_word_sub u_word_sub (
    .t_i (res_i),
    .p_i (p_i),
    .b_i (b_in),
    .d_o (diff),
    .b_o (b_out)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    j_d       = j_q;
    borrow_d  = borrow_q;
    sel_d     = sel_q;
    overrun_d = overrun_q;
    word_we   = 1'b0;
    wr_idx    = k_q;
    b_in      = borrow_q;

    case (state_q)
      ST_IDLE: begin
        // Word 0 always starts the borrow chain from zero.
        wr_idx = '0;
        b_in   = 1'b0;
        if (res_valid_i) begin
          word_we  = 1'b1;
          borrow_d = b_out;
          k_d      = ONE;
          state_d  = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (res_valid_i) begin
          word_we  = 1'b1;
          borrow_d = b_out;
          if (k_q == LAST_IDX) begin
            k_d     = '0;
            state_d = ST_SELECT;
          end else begin
            k_d = k_q + ONE;
          end
        end
      end

      ST_SELECT: begin
        sel_d   = ~borrow_q;
        j_d     = '0;
        state_d = ST_OUTPUT;
        if (res_valid_i) overrun_d = 1'b1;
      end

      ST_OUTPUT: begin
        if (res_valid_i) overrun_d = 1'b1;
        if (out_ready_i) begin
          if (j_q == LAST_IDX) begin
            j_d     = '0;
            state_d = ST_IDLE;
          end else begin
            j_d = j_q + ONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      j_q       <= '0;
      borrow_q  <= 1'b0;
      sel_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      j_q       <= j_d;
      borrow_q  <= borrow_d;
      sel_q     <= sel_d;
      overrun_q <= overrun_d;
    end
  end

  // Buffers carry no reset; a discarded operand is simply overwritten later.
  always_ff @(posedge clock_i) begin
    if (word_we && !reset_i) begin
      t_mem_q[wr_idx] <= res_i;
      d_mem_q[wr_idx] <= diff;
    end
  end

  always_comb begin
    out_valid_o = (state_q == ST_OUTPUT);
    out_last_o  = out_valid_o && (j_q == LAST_IDX);
    busy_o      = (state_q == ST_SELECT) || (state_q == ST_OUTPUT);
    overrun_o   = overrun_q;
    out_o       = '0;
    if (out_valid_o) out_o = sel_q ? d_mem_q[j_q] : t_mem_q[j_q];
  end

endmodule

// File: tb/tb_fios_final_sub.sv
// Self-checking bench for fios_final_sub with S=4: directed table, corner
// sequences and randomized operands against a big-integer reference model.
module tb_fios_final_sub;

  localparam int S = 4;
  localparam int W = 17;
  typedef logic [S-1:0][W-1:0] op_t;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         res_valid_i = 1'b0;
  logic [W-1:0] res_i = '0;
  logic [W-1:0] p_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [W-1:0] out_o;
  logic         out_last_o;
  logic         busy_o;
  logic         overrun_o;

  int n_checks = 0;
  int n_pass   = 0;

  fios_final_sub #(.S(S)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .res_valid_i (res_valid_i),
    .res_i       (res_i),
    .p_i         (p_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_o       (out_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    op_t t;
    op_t p;
    op_t e;
  } vec_t;

  vec_t vecs [5];

  // Reference: treat operands as plain integers; output T-p when T >= p, else T.
  function automatic op_t ref_out(input op_t t, input op_t p);
    logic [S*W-1:0] tv, pv;
    tv = t;
    pv = p;
    return (tv >= pv) ? op_t'(tv - pv) : op_t'(tv);
  endfunction

  task automatic chk(input string name, input logic [S*W-1:0] act, input logic [S*W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_word(input logic [W-1:0] t, input logic [W-1:0] p);
    res_valid_i = 1'b1;
    res_i       = t;
    p_i         = p;
    @(negedge clock_i);
    res_valid_i = 1'b0;
    res_i       = '0;
    p_i         = '0;
  endtask

  task automatic send_op(input op_t t, input op_t p, input int max_gap);
    for (int w = 0; w < S; w++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) @(negedge clock_i);
      drive_word(t[w], p[w]);
    end
  endtask

  task automatic recv_op(input int stall_pct, output op_t got, output int nwords, output logic last_ok);
    int budget;
    logic rdy;
    got     = '0;
    nwords  = 0;
    last_ok = 1'b1;
    budget  = 0;
    while (nwords < S && budget < 200) begin
      rdy = (int'($urandom_range(0, 99)) >= stall_pct);
      out_ready_i = rdy;
      if (out_valid_o && rdy) begin
        got[nwords] = out_o;
        if (out_last_o !== (nwords == S - 1)) last_ok = 1'b0;
        nwords++;
      end
      @(negedge clock_i);
      budget++;
    end
    out_ready_i = 1'b0;
  endtask

  task automatic run_check(input string name, input op_t t, input op_t p, input op_t e,
                           input int max_gap, input int stall_pct);
    op_t  got;
    int   nwords;
    logic last_ok;
    send_op(t, p, max_gap);
    chk({name, "_select_valid"}, out_valid_o, 0);
    chk({name, "_select_busy"}, busy_o, 1);
    @(negedge clock_i);
    chk({name, "_latency_valid"}, out_valid_o, 1);
    recv_op(stall_pct, got, nwords, last_ok);
    chk({name, "_nwords"}, nwords, S);
    chk({name, "_data"}, got, e);
    chk({name, "_last"}, last_ok, 1);
    chk({name, "_idle_after"}, {busy_o, out_valid_o, out_o}, 0);
  endtask

  initial begin
    op_t  t, p;
    op_t  got;
    int   nwords;
    logic last_ok;

    vecs[0].t = {17'd0, 17'd0, 17'd0, 17'd5};
    vecs[0].p = {17'd0, 17'd0, 17'd0, 17'd3};
    vecs[0].e = {17'd0, 17'd0, 17'd0, 17'd2};
    vecs[1].t = {17'd0, 17'd0, 17'd0, 17'd1};
    vecs[1].p = {17'd0, 17'd0, 17'd0, 17'd3};
    vecs[1].e = {17'd0, 17'd0, 17'd0, 17'd1};
    vecs[2].t = {17'd0, 17'd0, 17'd1, 17'd0};
    vecs[2].p = {17'd0, 17'd0, 17'd0, 17'h1FFFF};
    vecs[2].e = {17'd0, 17'd0, 17'd0, 17'd1};
    vecs[3].t = {17'd1, 17'd0, 17'd2, 17'd7};
    vecs[3].p = {17'd1, 17'd0, 17'd2, 17'd7};
    vecs[3].e = {17'd0, 17'd0, 17'd0, 17'd0};
    vecs[4].t = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
    vecs[4].p = {17'd1, 17'd0, 17'd0, 17'd0};
    vecs[4].e = {17'h1FFFE, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};

    repeat (2) @(negedge clock_i);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_out", out_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    reset_i = 1'b0;

    // Back-to-back directed operands, always ready.
    for (int i = 0; i < 5; i++)
      run_check($sformatf("vec%0d", i), vecs[i].t, vecs[i].p, vecs[i].e, 0, 0);

    // Downstream stall for three cycles at j=1.
    send_op(vecs[0].t, vecs[0].p, 0);
    @(negedge clock_i);
    out_ready_i = 1'b1;
    chk("stall_w0", {out_valid_o, out_o}, {1'b1, 17'd2});
    @(negedge clock_i);
    out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_hold%0d", c), {out_valid_o, out_last_o, out_o}, {2'b10, 17'd0});
      @(negedge clock_i);
    end
    out_ready_i = 1'b1;
    for (int jj = 1; jj < S; jj++) begin
      chk($sformatf("stall_w%0d", jj), {out_valid_o, out_last_o, out_o}, {1'b1, jj == S - 1, 17'd0});
      @(negedge clock_i);
    end
    out_ready_i = 1'b0;
    chk("stall_done", out_valid_o, 0);

    // Word arriving during OUTPUT raises the sticky overrun flag.
    chk("ovr_clear", overrun_o, 0);
    send_op(vecs[4].t, vecs[4].p, 0);
    @(negedge clock_i);
    drive_word(17'h15555, 17'h0AAAA);
    chk("ovr_set", overrun_o, 1);
    recv_op(0, got, nwords, last_ok);
    chk("ovr_data", got, vecs[4].e);
    chk("ovr_nwords", nwords, S);
    repeat (3) @(negedge clock_i);
    chk("ovr_sticky", overrun_o, 1);
    reset_i = 1'b1;
    res_valid_i = 1'b1;
    res_i = 17'h1234;
    p_i = 17'h0001;
    @(negedge clock_i);
    reset_i = 1'b0;
    res_valid_i = 1'b0;
    chk("ovr_reset", {overrun_o, busy_o}, 0);
    run_check("after_rst_valid", vecs[1].t, vecs[1].p, vecs[1].e, 0, 0);

    // Reset in the middle of OUTPUT at j=2.
    send_op(vecs[4].t, vecs[4].p, 0);
    @(negedge clock_i);
    out_ready_i = 1'b1;
    repeat (2) @(negedge clock_i);
    out_ready_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    chk("midrst_state", {out_valid_o, busy_o, out_last_o, out_o}, 0);
    run_check("midrst_fresh", vecs[3].t, vecs[3].p, vecs[3].e, 0, 0);

    // Randomized operands with input gaps and output stalls.
    for (int r = 0; r < 40; r++) begin
      for (int w = 0; w < S; w++) begin
        t[w] = W'($urandom);
        p[w] = W'($urandom);
      end
      case (r % 5)
        0: p = t;
        1: p[S-1] = t[S-1];
        default: ;
      endcase
      run_check($sformatf("rnd%0d", r), t, p, ref_out(t, p), 2, 30);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fios_final_sub.md
FIOS_FINAL_SUB -- requirements
Module: fios_final_sub

Interface
REQ-001 Parameter S, default 8, number of 17-bit words per operand; legal range 2..64.
REQ-002 clock_i  in  1  single clock; all state updates on its rising edge.
REQ-003 reset_i  in  1  reset, synchronous and active-high.
REQ-004 res_valid_i  in  1  res_i/p_i carry a valid word this cycle; no ready, upstream PE chain cannot stall.
REQ-005 res_i  in  17  FIOS result word T_k from the last PE RES_o, LSW first.
REQ-006 p_i  in  17  modulus word p_k, aligned with res_i.
REQ-007 out_valid_o  out  1  out_o holds a valid reduced word.
REQ-008 out_ready_i  in  1  downstream accepts out_o when high together with out_valid_o.
REQ-009 out_o  out  17  reduced result word, LSW first.
REQ-010 out_last_o  out  1  high with word S-1 of out_o.
REQ-011 busy_o  out  1  high in SELECT and OUTPUT states.
REQ-012 overrun_o  out  1  sticky error: word arrived while busy.

Function
REQ-013 FSM states IDLE, COLLECT, SELECT, OUTPUT; encoding in shared package.
REQ-014 IDLE: res_valid_i=1 stores word 0, goes to COLLECT with word counter k=1.
REQ-015 COLLECT: each res_valid_i=1 stores word k, increments k; gaps of res_valid_i=0 allowed, state held.
REQ-016 Per accepted word: D_k = (T_k - p_k - b_{k-1}) mod 2^17; b_k = 1 iff T_k < p_k + b_{k-1}; b_{-1}=0.
REQ-017 T_k and D_k stored in two S x 17 buffers; borrow stored in one register, cleared on word 0.
REQ-018 After word S-1 stored, next cycle is SELECT (one cycle): sel = ~b_{S-1} latched (1 means T >= p, output D).
REQ-019 OUTPUT: out_o = D_j if sel else T_j, j = output counter from 0; out_valid_o=1.
REQ-020 out_valid_o first high 2 cycles after the clock edge accepting word S-1.
REQ-021 out_o, out_last_o held stable while out_valid_o=1 and out_ready_i=0.
REQ-022 Handshake out_valid_o & out_ready_i advances j; transfer of j=S-1 returns FSM to IDLE next cycle.
REQ-023 IDLE reachable back-to-back: word 0 of next operand accepted in the first IDLE cycle.
REQ-024 res_valid_i=1 in SELECT or OUTPUT: word dropped, buffers unchanged, overrun_o set until reset.
REQ-025 Counters k and j width $clog2(S); never wrap past S-1 (transition precedes wrap).
REQ-026 T == p yields all-zero output; T assumed < 2p, no second subtraction performed.
REQ-027 out_o drives 0 when out_valid_o=0.

Reset
REQ-028 reset_i=1 at any edge: FSM to IDLE, k=j=0, borrow=0, sel=0, overrun_o=0.
REQ-029 Outputs after reset: out_valid_o=0, out_o=0, out_last_o=0, busy_o=0.
REQ-030 Reset mid-COLLECT or mid-OUTPUT discards the operand; buffer contents need no reset.
REQ-031 res_valid_i sampled in the reset cycle is ignored.

Structure
REQ-032 Package fios_pkg holds WORD_W=17 and the state enum type fios_final_sub_state_t.
REQ-033 One sub-module, fios_word_sub: combinational 17-bit subtract-with-borrow (T, p, b_in -> D, b_out).
REQ-034 Buffers inferred as registers or distributed RAM; no DSP primitives used.

Verification (S=4, words listed LSW first)
REQ-035 T={5,0,0,0}, p={3,0,0,0}, ready=1 -> out {2,0,0,0}, last on word 3, valid 2 cycles after last input.
REQ-036 T={1,0,0,0}, p={3,0,0,0} -> final borrow 1, out {1,0,0,0}; T={0,1,0,0}, p={1FFFF,0,0,0} -> out {1,0,0,0}.
REQ-037 T=p={7,2,0,1} -> out {0,0,0,0}.
REQ-038 Case REQ-035 with out_ready_i=0 for 3 cycles at j=1 -> out_o=0 held stable, no word lost or repeated.
REQ-039 res_valid_i=1 during OUTPUT -> overrun_o=1 and stays 1; output words unchanged.
REQ-040 reset_i pulsed at j=2 -> next cycle out_valid_o=0, busy_o=0; fresh operand then processed correctly.
